// File: rtl/rf_bypass_param.sv
// rf_bypass_param: WIDTH x DEPTH register file with 2 combinational read ports, 1 write port, and a per-register busy scoreboard.
// Reads take 0 cycles, with optional same-cycle write bypass; writes, reservations and err take effect on the next clk edge; no backpressure.
module rf_bypass_param #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int SELW    = 3,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SELW-1:0]   read1regsel,
    input  logic [SELW-1:0]   read2regsel,
    input  logic [SELW-1:0]   writeregsel,
    input  logic [WIDTH-1:0]  writedata,
    input  logic              write,
    input  logic [SELW-1:0]   resvsel,
    input  logic              resv,
    output logic [WIDTH-1:0]  read1data,
    output logic [WIDTH-1:0]  read2data,
    output logic              read1busy,
    output logic              read2busy,
    output logic              err
);
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             err_q;
    logic             err_d;
    logic             wr_ok;
    logic             rv_ok;
    logic             rv_dup;

    // One extra bit so DEPTH == 2**SELW still compares correctly.
    function automatic logic in_range(input logic [SELW-1:0] sel);
        return {1'b0, sel} < (SELW+1)'(DEPTH);
    endfunction

    function automatic logic sel_valid(input logic [SELW-1:0] sel);
        return in_range(sel) && !(ZERO_R0 != 0 && sel == '0);
    endfunction

    // Returns {busy, data} for one read port.
    function automatic logic [WIDTH:0] rd_port(input logic [SELW-1:0] sel);
        logic [WIDTH:0] r;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel == SELW'(i) && !(ZERO_R0 != 0 && i == 0)) begin
                r = {busy_q[i], regs_q[i]};
            end
        end
        if (BYPASS != 0 && wr_ok && writeregsel == sel) begin
            r = {1'b0, writedata};
        end
        return r;
    endfunction

    always_comb begin
        wr_ok  = write && sel_valid(writeregsel);
        rv_ok  = resv && sel_valid(resvsel);
        regs_d = regs_q;
        busy_d = busy_q;
        rv_dup = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_ok && writeregsel == SELW'(i)) begin
                regs_d[i] = writedata;
                busy_d[i] = 1'b0;
            end
            // A same-edge reservation to the written register wins: the new producer is pending.
            if (rv_ok && resvsel == SELW'(i)) begin
                busy_d[i] = 1'b1;
                if (busy_q[i] && !(wr_ok && writeregsel == resvsel)) begin
                    rv_dup = 1'b1;
                end
            end
        end
        err_d = err_q
              | (write && !in_range(writeregsel))
              | (resv && !in_range(resvsel))
              | rv_dup;
    end

    always_comb begin
        {read1busy, read1data} = rd_port(read1regsel);
        {read2busy, read2data} = rd_port(read2regsel);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_rf_bypass_param.sv
// Two instances share the stimulus: A = DEPTH 6 with bypass, B = DEPTH 8 without bypass and with a hard zero r0.
module tb_rf_bypass_param;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  r1s, r2s, ws, rs;
    logic [15:0] wd;
    logic        we, rv;
    logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        a_b1, a_b2, a_err, b_b1, b_b2, b_err;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] exp_q [$];
    logic [15:0] e;

    always #5 clk = ~clk;

    rf_bypass_param #(.WIDTH(16), .DEPTH(6), .SELW(3), .BYPASS(1), .ZERO_R0(0)) dut_a (
        .clk(clk), .rst(rst), .read1regsel(r1s), .read2regsel(r2s), .writeregsel(ws),
        .writedata(wd), .write(we), .resvsel(rs), .resv(rv), .read1data(a_rd1),
        .read2data(a_rd2), .read1busy(a_b1), .read2busy(a_b2), .err(a_err));

    rf_bypass_param #(.WIDTH(16), .DEPTH(8), .SELW(3), .BYPASS(0), .ZERO_R0(1)) dut_b (
        .clk(clk), .rst(rst), .read1regsel(r1s), .read2regsel(r2s), .writeregsel(ws),
        .writedata(wd), .write(we), .resvsel(rs), .resv(rv), .read1data(b_rd1),
        .read2data(b_rd2), .read1busy(b_b1), .read2busy(b_b2), .err(b_err));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0;
        rv = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; we = 1'b1; ws = 3'd3; wd = 16'hBEEF; rv = 1'b1; rs = 3'd3; r1s = 3'd3; r2s = 3'd3;
        tick();
        rst = 1'b1;
        idle();
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0000); exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (a_rd1 !== e) begin n_bad++; $display("FAIL reset_data a_rd1=%h expected %h", a_rd1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (16'(a_b1) !== e) begin n_bad++; $display("FAIL reset_busy a_b1=%0d expected %0d", a_b1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (16'(a_err) !== e) begin n_bad++; $display("FAIL reset_err a_err=%0d expected %0d", a_err, e); end
        e = exp_q.pop_front(); n_vec++;
        if (16'(b_err) !== e) begin n_bad++; $display("FAIL reset_err b_err=%0d expected %0d", b_err, e); end
    endtask

    task automatic test_write();
        r1s = 3'd3; ws = 3'd3; wd = 16'hBEEF; we = 1'b1;
        exp_q.push_back(16'h0000); exp_q.push_back(16'hBEEF);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (b_rd1 !== e) begin n_bad++; $display("FAIL write_pre b_rd1=%h expected %h", b_rd1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (a_rd1 !== e) begin n_bad++; $display("FAIL write_pre_byp a_rd1=%h expected %h", a_rd1, e); end
        tick();
        idle();
        exp_q.push_back(16'hBEEF); exp_q.push_back(16'hBEEF); exp_q.push_back(16'h0000);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (b_rd1 !== e) begin n_bad++; $display("FAIL write_post b_rd1=%h expected %h", b_rd1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (a_rd1 !== e) begin n_bad++; $display("FAIL write_post a_rd1=%h expected %h", a_rd1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (16'(a_err) !== e) begin n_bad++; $display("FAIL write_err a_err=%0d expected %0d", a_err, e); end
    endtask

    task automatic test_bypass();
        ws = 3'd5; wd = 16'h1111; we = 1'b1;
        tick();
        wd = 16'h2222; r1s = 3'd5; r2s = 3'd5;
        exp_q.push_back(16'h2222); exp_q.push_back(16'h2222); exp_q.push_back(16'h1111); exp_q.push_back(16'h1111);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (a_rd1 !== e) begin n_bad++; $display("FAIL bypass a_rd1=%h expected %h", a_rd1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (a_rd2 !== e) begin n_bad++; $display("FAIL bypass a_rd2=%h expected %h", a_rd2, e); end
        e = exp_q.pop_front(); n_vec++;
        if (b_rd1 !== e) begin n_bad++; $display("FAIL nobypass b_rd1=%h expected %h", b_rd1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (b_rd2 !== e) begin n_bad++; $display("FAIL nobypass b_rd2=%h expected %h", b_rd2, e); end
        tick();
        idle();
        exp_q.push_back(16'h2222); exp_q.push_back(16'h2222);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (b_rd1 !== e) begin n_bad++; $display("FAIL nobypass_post b_rd1=%h expected %h", b_rd1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (b_rd2 !== e) begin n_bad++; $display("FAIL nobypass_post b_rd2=%h expected %h", b_rd2, e); end
    endtask

    task automatic test_scoreboard();
        do_reset();
        rv = 1'b1; rs = 3'd2; r1s = 3'd2; r2s = 3'd2;
        tick();
        rv = 1'b0;
        exp_q.push_back(16'h0001); exp_q.push_back(16'h0001);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (16'(a_b1) !== e) begin n_bad++; $display("FAIL resv_busy a_b1=%0d expected %0d", a_b1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (16'(b_b1) !== e) begin n_bad++; $display("FAIL resv_busy b_b1=%0d expected %0d", b_b1, e); end
        we = 1'b1; ws = 3'd2; wd = 16'h00AA;
        exp_q.push_back(16'h0000); exp_q.push_back(16'h00AA); exp_q.push_back(16'h0001); exp_q.push_back(16'h0000);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (16'(a_b1) !== e) begin n_bad++; $display("FAIL wr_busy_byp a_b1=%0d expected %0d", a_b1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (a_rd1 !== e) begin n_bad++; $display("FAIL wr_data_byp a_rd1=%h expected %h", a_rd1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (16'(b_b1) !== e) begin n_bad++; $display("FAIL wr_busy_pre b_b1=%0d expected %0d", b_b1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (b_rd1 !== e) begin n_bad++; $display("FAIL wr_data_pre b_rd1=%h expected %h", b_rd1, e); end
        tick();
        we = 1'b0;
        exp_q.push_back(16'h0000); exp_q.push_back(16'h00AA);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (16'(b_b1) !== e) begin n_bad++; $display("FAIL wr_busy_post b_b1=%0d expected %0d", b_b1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (b_rd1 !== e) begin n_bad++; $display("FAIL wr_data_post b_rd1=%h expected %h", b_rd1, e); end
        we = 1'b1; ws = 3'd2; wd = 16'h0055; rv = 1'b1; rs = 3'd2;
        tick();
        idle();
        exp_q.push_back(16'h0001); exp_q.push_back(16'h0001); exp_q.push_back(16'h0055); exp_q.push_back(16'h0000);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (16'(a_b2) !== e) begin n_bad++; $display("FAIL wr_resv_busy a_b2=%0d expected %0d", a_b2, e); end
        e = exp_q.pop_front(); n_vec++;
        if (16'(b_b1) !== e) begin n_bad++; $display("FAIL wr_resv_busy b_b1=%0d expected %0d", b_b1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (b_rd1 !== e) begin n_bad++; $display("FAIL wr_resv_data b_rd1=%h expected %h", b_rd1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (16'(a_err) !== e) begin n_bad++; $display("FAIL wr_resv_err a_err=%0d expected %0d", a_err, e); end
    endtask

    task automatic test_errors();
        do_reset();
        r1s = 3'd7; we = 1'b1; ws = 3'd7; wd = 16'hDEAD;
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (a_rd1 !== e) begin n_bad++; $display("FAIL oor_read a_rd1=%h expected %h", a_rd1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (16'(a_b1) !== e) begin n_bad++; $display("FAIL oor_busy a_b1=%0d expected %0d", a_b1, e); end
        tick();
        idle();
        exp_q.push_back(16'h0001); exp_q.push_back(16'h0000); exp_q.push_back(16'hDEAD);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (16'(a_err) !== e) begin n_bad++; $display("FAIL oor_write_err a_err=%0d expected %0d", a_err, e); end
        e = exp_q.pop_front(); n_vec++;
        if (16'(b_err) !== e) begin n_bad++; $display("FAIL inrange_err b_err=%0d expected %0d", b_err, e); end
        e = exp_q.pop_front(); n_vec++;
        if (b_rd1 !== e) begin n_bad++; $display("FAIL inrange_wr b_rd1=%h expected %h", b_rd1, e); end
        for (int i = 0; i < 6; i++) begin
            r1s = 3'(i);
            exp_q.push_back(16'h0000);
            #1;
            e = exp_q.pop_front(); n_vec++;
            if (a_rd1 !== e) begin n_bad++; $display("FAIL oor_nochange r%0d a_rd1=%h expected %h", i, a_rd1, e); end
        end
        tick();
        tick();
        exp_q.push_back(16'h0001);
        e = exp_q.pop_front(); n_vec++;
        if (16'(a_err) !== e) begin n_bad++; $display("FAIL err_held a_err=%0d expected %0d", a_err, e); end
        do_reset();
        exp_q.push_back(16'h0000);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (16'(a_err) !== e) begin n_bad++; $display("FAIL err_clear a_err=%0d expected %0d", a_err, e); end
        rv = 1'b1; rs = 3'd6;
        tick();
        idle();
        exp_q.push_back(16'h0001); exp_q.push_back(16'h0000);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (16'(a_err) !== e) begin n_bad++; $display("FAIL oor_resv a_err=%0d expected %0d", a_err, e); end
        e = exp_q.pop_front(); n_vec++;
        if (16'(b_err) !== e) begin n_bad++; $display("FAIL inrange_resv b_err=%0d expected %0d", b_err, e); end
        do_reset();
        rv = 1'b1; rs = 3'd1;
        tick();
        tick();
        idle();
        exp_q.push_back(16'h0001); exp_q.push_back(16'h0001);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (16'(a_err) !== e) begin n_bad++; $display("FAIL double_resv a_err=%0d expected %0d", a_err, e); end
        e = exp_q.pop_front(); n_vec++;
        if (16'(b_err) !== e) begin n_bad++; $display("FAIL double_resv b_err=%0d expected %0d", b_err, e); end
        do_reset();
        rv = 1'b1; rs = 3'd1;
        tick();
        we = 1'b1; ws = 3'd1; wd = 16'h0777;
        tick();
        idle();
        r1s = 3'd1;
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0000); exp_q.push_back(16'h0001); exp_q.push_back(16'h0777);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (16'(a_err) !== e) begin n_bad++; $display("FAIL resv_wr_same a_err=%0d expected %0d", a_err, e); end
        e = exp_q.pop_front(); n_vec++;
        if (16'(b_err) !== e) begin n_bad++; $display("FAIL resv_wr_same b_err=%0d expected %0d", b_err, e); end
        e = exp_q.pop_front(); n_vec++;
        if (16'(a_b1) !== e) begin n_bad++; $display("FAIL resv_wr_same a_b1=%0d expected %0d", a_b1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (b_rd1 !== e) begin n_bad++; $display("FAIL resv_wr_same b_rd1=%h expected %h", b_rd1, e); end
        rv = 1'b1; rs = 3'd1; we = 1'b1; ws = 3'd2; wd = 16'h0001;
        tick();
        idle();
        exp_q.push_back(16'h0001);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (16'(a_err) !== e) begin n_bad++; $display("FAIL resv_wr_other a_err=%0d expected %0d", a_err, e); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        we = 1'b1; ws = 3'd0; wd = 16'hFFFF; rv = 1'b1; rs = 3'd0; r1s = 3'd0; r2s = 3'd0;
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0000); exp_q.push_back(16'hFFFF);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (b_rd1 !== e) begin n_bad++; $display("FAIL zero_pre b_rd1=%h expected %h", b_rd1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (16'(b_b1) !== e) begin n_bad++; $display("FAIL zero_pre b_b1=%0d expected %0d", b_b1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (a_rd1 !== e) begin n_bad++; $display("FAIL r0_bypass a_rd1=%h expected %h", a_rd1, e); end
        tick();
        we = 1'b0;
        tick();
        idle();
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
        exp_q.push_back(16'hFFFF); exp_q.push_back(16'h0001); exp_q.push_back(16'h0001);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (b_rd2 !== e) begin n_bad++; $display("FAIL zero_post b_rd2=%h expected %h", b_rd2, e); end
        e = exp_q.pop_front(); n_vec++;
        if (16'(b_b2) !== e) begin n_bad++; $display("FAIL zero_post b_b2=%0d expected %0d", b_b2, e); end
        e = exp_q.pop_front(); n_vec++;
        if (16'(b_err) !== e) begin n_bad++; $display("FAIL zero_err b_err=%0d expected %0d", b_err, e); end
        e = exp_q.pop_front(); n_vec++;
        if (a_rd1 !== e) begin n_bad++; $display("FAIL r0_stored a_rd1=%h expected %h", a_rd1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (16'(a_b1) !== e) begin n_bad++; $display("FAIL r0_busy a_b1=%0d expected %0d", a_b1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (16'(a_err) !== e) begin n_bad++; $display("FAIL r0_double_resv a_err=%0d expected %0d", a_err, e); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        we = 1'b1; ws = 3'd4; wd = 16'h5A5A;
        tick();
        we = 1'b0; rv = 1'b1; rs = 3'd4;
        tick();
        rv = 1'b0; r1s = 3'd4;
        exp_q.push_back(16'h0001); exp_q.push_back(16'h5A5A);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (16'(b_b1) !== e) begin n_bad++; $display("FAIL midop_pre b_b1=%0d expected %0d", b_b1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (a_rd1 !== e) begin n_bad++; $display("FAIL midop_pre a_rd1=%h expected %h", a_rd1, e); end
        rst = 1'b0; we = 1'b1; ws = 3'd4; wd = 16'h1234; rv = 1'b1; rs = 3'd4;
        tick();
        rst = 1'b1;
        idle();
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
        #1;
        e = exp_q.pop_front(); n_vec++;
        if (a_rd1 !== e) begin n_bad++; $display("FAIL midop_post a_rd1=%h expected %h", a_rd1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (b_rd1 !== e) begin n_bad++; $display("FAIL midop_post b_rd1=%h expected %h", b_rd1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (16'(a_b1) !== e) begin n_bad++; $display("FAIL midop_post a_b1=%0d expected %0d", a_b1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (16'(b_b1) !== e) begin n_bad++; $display("FAIL midop_post b_b1=%0d expected %0d", b_b1, e); end
        e = exp_q.pop_front(); n_vec++;
        if (16'(a_err) !== e) begin n_bad++; $display("FAIL midop_post a_err=%0d expected %0d", a_err, e); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 1; i < 6; i++) begin
            ws = 3'(i); wd = 16'($urandom); we = 1'b1;
            exp_q.push_back(wd);
            tick();
        end
        idle();
        for (int i = 1; i < 6; i++) begin
            r1s = 3'(i); r2s = 3'(i);
            #1;
            e = exp_q.pop_front();
            n_vec++;
            if (a_rd1 !== e) begin n_bad++; $display("FAIL b2b r%0d a_rd1=%h expected %h", i, a_rd1, e); end
            n_vec++;
            if (a_rd2 !== e) begin n_bad++; $display("FAIL b2b r%0d a_rd2=%h expected %h", i, a_rd2, e); end
            n_vec++;
            if (b_rd1 !== e) begin n_bad++; $display("FAIL b2b r%0d b_rd1=%h expected %h", i, b_rd1, e); end
        end
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; rv = 1'b0; ws = '0; rs = '0; wd = '0; r1s = '0; r2s = '0;
        test_reset();
        test_write();
        test_bypass();
        test_scoreboard();
        test_errors();
        test_zero_reg();
        test_reset_midop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rf_bypass_param.md
Name: rf_bypass_param

Overview:
Parametrised successor to the 8x16 register file. It has configurable width and depth, two combinational read ports and one write port. Optional write-to-read bypass and an optional hard-wired zero register. A per-register busy scoreboard lets the decode stage reserve a destination and detect read-after-write hazards. It sits between decode and execute in the pipelined datapath and replaces the fixed-size file.

Parameters:
WIDTH, 16, data width of each register in bits
DEPTH, 8, number of registers (2..2^SELW)
SELW, 3, width of every register-select input
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see stored value only
ZERO_R0, 0, 1 = register 0 reads as zero and ignores writes and reservations

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-low reset; 0 at a rising clk edge resets all state
read1regsel  input  SELW  read port 1 select
read2regsel  input  SELW  read port 2 select
writeregsel  input  SELW  write select
writedata  input  WIDTH  write data
write  input  1  write enable
resvsel  input  SELW  reservation select
resv  input  1  reservation strobe, marks resvsel busy
read1data  output  WIDTH  read port 1 data
read2data  output  WIDTH  read port 2 data
read1busy  output  1  register selected by port 1 has a pending producer
read2busy  output  1  register selected by port 2 has a pending producer
err  output  1  sticky registered error flag

Behaviour:
- Reset: one clk edge with rst=0 clears all registers to 0, all busy bits to 0 and err to 0. Write, resv and error detection are ignored on that edge.
- Reset mid-operation: a concurrent write or reservation is discarded.
- Valid select: sel < DEPTH, and not (ZERO_R0=1 and sel=0).
- Write: on an edge with rst=1, write=1 and a valid writeregsel, the register takes writedata and its busy bit clears. Latency is 1 edge to stored state.
- Reserve: on an edge with rst=1, resv=1 and a valid resvsel, busy[resvsel] is set.
- Write and reserve to the same register on the same edge: data updates and busy ends at 1, because the new producer wins. Write and reserve to different registers are independent.
- Write or resv with ZERO_R0=1 and sel=0: silently ignored, no error.
- Reads are combinational, with zero cycles of latency.
  - sel >= DEPTH: data 0, busy 0.
  - ZERO_R0=1 and sel=0: data 0, busy 0.
  - BYPASS=1, write=1, valid writeregsel equal to the read select: data = writedata, busy = 0. The bypass is active regardless of rst, but the value is not stored if rst=0.
  - Otherwise: data = stored register, busy = busy bit.
- Both read ports may select the same register and return identical values.
- err is registered. It is set on the edge after an offending cycle (rst=1) and held until reset. Offending cycles are:
  - write=1 with writeregsel >= DEPTH;
  - resv=1 with resvsel >= DEPTH;
  - resv=1 to a valid register whose busy bit is already 1 and is not being cleared by a same-edge write to it.
- Out-of-range writes and reservations modify no state.
- Width rules: no arithmetic on data. Select comparisons are unsigned over SELW bits.
- DEPTH=8, WIDTH=16, BYPASS=0, ZERO_R0=0 gives the same read/write behaviour as the existing 8x16 file, plus the scoreboard.

Test Plan:
- Reset then write: rst=0 for one edge, then write r3=16'hBEEF. Before the edge read1(r3)=0. After the edge read1(r3)=16'hBEEF and err=0.
- Bypass: BYPASS=1, r5=16'h1111 stored. In the same cycle write r5=16'h2222 with read1sel=read2sel=5: both reads show 16'h2222 before the edge. With BYPASS=0 both show 16'h1111 until the edge.
- Scoreboard:
  - resv r2, then next cycle: read1busy=1 for sel 2.
  - Write r2=16'h00AA: busy still 1 that cycle (bypass shows 0 if BYPASS=1), 0 after the edge.
  - Simultaneous write+resv r2: busy stays 1 and data=new value.
- Errors:
  - DEPTH=6, write sel 7: no register changes, err=1 one edge later and held.
  - Double resv r1 without an intervening write: err=1.
  - resv r1 plus same-edge write r1: err stays 0.
  - rst=0 clears err.
- Zero register: ZERO_R0=1, write r0=16'hFFFF and resv r0. Read r0 gives data 0, busy 0, err 0.
- Reset mid-operation: r4 busy holding 16'h5A5A, then rst=0 with write r4=16'h1234. After the edge r4=0, busy 0, err 0.
